// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins. Out-of-order
// MDU results wait in a small FIFO and are written when the pipe leaves the port free.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pipe_valid,
  input  logic [ADDR_W-1:0]    pipe_waddr,
  input  logic [DATA_W-1:0]    pipe_wdata,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [ADDR_W-1:0]    mdu_waddr,
  input  logic [DATA_W-1:0]    mdu_wdata,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 pipe_stall,
  output logic                 fifo_full
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX) + 1;

  logic              r_live [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ST_W-1:0]   r_starve;
  logic              r_stall;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic              w_pipe_wr;
  logic              w_full;
  logic              w_head_valid;
  logic              w_head_live;
  logic              w_head_issue;
  logic              w_pop;
  logic              w_loss;
  logic              w_push;
  logic              w_push_live;
  logic              w_starve_hit;
  logic [NREG-1:0]   w_slot_mask [FIFO_DEPTH];
  logic [NREG-1:0]   w_busy;

  assign w_pipe_wr    = pipe_valid & (pipe_waddr != '0);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_head_live  = w_head_valid & r_live[r_rd_ptr];
  assign w_head_issue = ~w_pipe_wr & w_head_live;
  // A dead head is dropped even while the pipe owns the write port.
  assign w_pop        = w_head_issue | (w_head_valid & ~r_live[r_rd_ptr]);
  assign w_loss       = w_pipe_wr & w_head_live;
  assign w_push       = mdu_valid & mdu_ready & (mdu_waddr != '0);
  assign w_push_live  = ~(w_pipe_wr & (pipe_waddr == mdu_waddr));
  assign w_starve_hit = w_loss & (r_starve == ST_W'(STARVE_MAX - 1));

  assign mdu_ready  = resetn & ~w_full;
  assign fifo_full  = w_full;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign pipe_stall = r_stall;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot_mask
      assign w_slot_mask[gi] = r_live[gi] ? (NREG'(1) << r_addr[gi]) : '0;
    end
  endgenerate

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_busy = w_busy | w_slot_mask[i];
    end
    busy_mask = w_busy & ~NREG'(1);
  end

  // Free slots are kept dead, so the squash compare may run over every slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_live[i] <= 1'b0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i))) begin
          r_live[i] <= w_push_live;
          r_addr[i] <= mdu_waddr;
          r_data[i] <= mdu_wdata;
        end else if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
          r_live[i] <= 1'b0;
        end else if (w_pipe_wr && (r_addr[i] == pipe_waddr)) begin
          r_live[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= w_starve_hit;
      if (w_pop || w_starve_hit) begin
        r_starve <= '0;
      end else if (w_loss) begin
        r_starve <= r_starve + ST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_pipe_wr) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= pipe_waddr;
      r_rf_wdata <= pipe_wdata;
    end else if (w_head_issue) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= r_addr[r_rd_ptr];
      r_rf_wdata <= r_data[r_rd_ptr];
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based model predicts every
// regfile write and per-cycle status; a monitor compares on each falling edge.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          pipe_valid = 1'b0;
  logic [AW-1:0] pipe_waddr = '0;
  logic [DW-1:0] pipe_wdata = '0;
  logic          mdu_valid = 1'b0;
  logic [AW-1:0] mdu_waddr = '0;
  logic [DW-1:0] mdu_wdata = '0;
  logic          mdu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy_mask;
  logic          pipe_stall;
  logic          fifo_full;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .pipe_stall(pipe_stall), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct { bit live; logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  ent_t m_fifo[$];
  wr_t  exp_q[$];
  int   m_starve = 0;
  bit   m_stall = 0;
  bit   m_we = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (m_fifo[i]) if (m_fifo[i].live) m[m_fifo[i].a] = 1'b1;
    return m & ~32'd1;
  endfunction

  // Reference model: one register write per cycle, pipe first, FIFO in order.
  bit   s_sq, s_hp, s_hl, s_acc, s_stall_n;
  wr_t  s_wr;
  ent_t s_ent;
  always @(posedge clk) begin
    if (resetn) begin
      s_sq  = pipe_valid && (pipe_waddr != 0);
      s_hp  = (m_fifo.size() > 0);
      s_hl  = s_hp && m_fifo[0].live;
      s_acc = mdu_valid && (m_fifo.size() < DEPTH);
      s_stall_n = 0;
      m_we = 0;
      if (s_sq) begin
        s_wr.a = pipe_waddr; s_wr.d = pipe_wdata;
        exp_q.push_back(s_wr);
        m_we = 1;
        if (s_hl) begin
          if (m_starve == SMAX - 1) begin s_stall_n = 1; m_starve = 0; end
          else m_starve++;
        end
      end else if (s_hl) begin
        s_wr.a = m_fifo[0].a; s_wr.d = m_fifo[0].d;
        exp_q.push_back(s_wr);
        m_we = 1;
        void'(m_fifo.pop_front());
        m_starve = 0;
      end
      if (s_hp && !s_hl) begin
        void'(m_fifo.pop_front());
        m_starve = 0;
      end
      if (s_sq) foreach (m_fifo[i]) if (m_fifo[i].a == pipe_waddr) m_fifo[i].live = 0;
      if (s_acc && mdu_waddr != 0) begin
        s_ent.live = !(s_sq && pipe_waddr == mdu_waddr);
        s_ent.a = mdu_waddr; s_ent.d = mdu_wdata;
        m_fifo.push_back(s_ent);
      end
      m_stall = s_stall_n;
    end
  end

  wr_t mon_wr;
  always @(negedge clk) begin
    if (resetn) begin
      chk("rf_we", 64'(rf_we), 64'(m_we));
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(rf_waddr), 64'hDEAD);
        end else begin
          mon_wr = exp_q.pop_front();
          $display("WR r%0d = %08h (expected r%0d = %08h)", rf_waddr, rf_wdata, mon_wr.a, mon_wr.d);
          chk("rf_waddr", 64'(rf_waddr), 64'(mon_wr.a));
          chk("rf_wdata", 64'(rf_wdata), 64'(mon_wr.d));
        end
      end
      chk("busy_mask", 64'(busy_mask), 64'(model_mask()));
      chk("fifo_full", 64'(fifo_full), 64'(m_fifo.size() == DEPTH));
      chk("mdu_ready", 64'(mdu_ready), 64'(m_fifo.size() < DEPTH));
      chk("pipe_stall", 64'(pipe_stall), 64'(m_stall));
    end
  end

  task automatic cyc(input bit pv, input int pa, input int pd, input bit mv, input int ma, input int md);
    pipe_valid = pv; pipe_waddr = AW'(pa); pipe_wdata = DW'(pd);
    mdu_valid  = mv; mdu_waddr  = AW'(ma); mdu_wdata  = DW'(md);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rf_we", 64'(rf_we), 0);
    chk("reset_rf_waddr", 64'(rf_waddr), 0);
    chk("reset_busy", 64'(busy_mask), 0);
    chk("reset_mdu_ready", 64'(mdu_ready), 0);
    chk("reset_stall", 64'(pipe_stall), 0);
    resetn = 1'b1;
    idle(2);

    cyc(1, 5, 'h1234, 0, 0, 0);
    chk("t1_we", 64'(rf_we), 1);
    chk("t1_addr", 64'(rf_waddr), 5);
    chk("t1_data", 64'(rf_wdata), 'h1234);

    cyc(1, 0, 'hFFFF, 0, 0, 0);
    chk("t2_r0_no_write", 64'(rf_we), 0);

    cyc(0, 0, 0, 1, 7, 'hAA);
    chk("t3_busy7", 64'(busy_mask[7]), 1);
    chk("t3_no_write_yet", 64'(rf_we), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_we", 64'(rf_we), 1);
    chk("t3_data", 64'(rf_wdata), 'hAA);
    chk("t3_busy_clear", 64'(busy_mask), 0);

    cyc(1, 9, 'h55, 1, 9, 'h77);
    chk("t4_busy9", 64'(busy_mask[9]), 0);
    chk("t4_data", 64'(rf_wdata), 'h55);
    idle(3);

    for (int i = 0; i < 4; i++) cyc(1, 1, 'h100 + i, 1, 10 + i, 'hB0 + i);
    chk("t5_full", 64'(fifo_full), 1);
    chk("t5_ready", 64'(mdu_ready), 0);
    cyc(0, 0, 0, 1, 15, 'hEE);
    idle(5);

    cyc(1, 2, 'h22, 1, 12, 'hC12);
    for (int i = 0; i < SMAX + 4; i++) cyc(!m_stall, 3, 'h300 + i, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 3; i++) cyc(1, 1, 'h400 + i, 1, 20 + i, 'hD0 + i);
    cyc(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    m_fifo.delete(); exp_q.delete();
    m_starve = 0; m_stall = 0; m_we = 0;
    #1;
    chk("t7_busy", 64'(busy_mask), 0);
    chk("t7_we", 64'(rf_we), 0);
    chk("t7_full", 64'(fifo_full), 0);
    @(negedge clk); #1;
    resetn = 1'b1;
    idle(6);

    for (int i = 0; i < 400; i++) begin
      cyc(!m_stall && ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom,
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
    end
    idle(10);
    chk("drain_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
